maze_timer: RTL and testbench

Countdown game timer for HangMaze: holds remaining time as three BCD digits (M:SS), decrements once per second while running, and applies a fixed time penalty on each wrong-guess event. It sits upstream of the per-digit hex/decimal conversion and seven-segment display path, and feeds it one 4-bit digit per display position. It also raises `expired` to the game-control FSM when time reaches 0:00.

---
 rtl/maze_timer_pkg.sv | 31 +++
 rtl/maze_timer_digit.sv | 37 +++
 rtl/maze_timer.sv | 136 +++++++++++++
 tb/tb_maze_timer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/maze_timer_pkg.sv
// Shared types, BCD limits and second/BCD conversion helpers for the HangMaze countdown timer.
package maze_timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        EXPIRED
    } timer_state_t;

    localparam logic [3:0] BCD_MAX_ONES = 4'd9;
    localparam logic [3:0] BCD_MAX_TENS = 4'd5;
    localparam logic [3:0] BCD_MAX_MIN  = 4'd9;

    function automatic logic [9:0] bcd_to_seconds(input logic [3:0] m, input logic [3:0] t,
                                                   input logic [3:0] o);
        return 10'(m) * 10'd60 + 10'(t) * 10'd10 + 10'(o);
    endfunction

    // Input range is 0..599, so the minutes quotient always fits one BCD nibble.
    function automatic logic [11:0] seconds_to_bcd(input logic [9:0] secs);
        logic [9:0] mins;
        logic [9:0] rem;
        logic [9:0] tens;
        mins = secs / 10'd60;
        rem  = secs - mins * 10'd60;
        tens = rem / 10'd10;
        return {mins[3:0], tens[3:0], 4'(rem - tens * 10'd10)};
    endfunction

endpackage

// File: rtl/maze_timer_digit.sv
// One registered BCD digit of the countdown borrow chain; wraps 0 -> MAX when it borrows.
module bcd_digit_down
    import maze_timer_pkg::*;
#(
    parameter logic [3:0] MAX  = BCD_MAX_ONES,
    parameter logic [3:0] INIT = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dec,
    input  logic       borrow_in,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] digit,
    output logic       borrow_out
);

    logic [3:0] r_digit;
    logic       w_step;

    // dec is the chain-wide one-second strobe; borrow_in says every lower digit is wrapping.
    assign w_step     = dec & borrow_in;
    assign borrow_out = w_step && (r_digit == 4'd0);
    assign digit      = r_digit;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= INIT;
        end else if (load) begin
            r_digit <= load_val;
        end else if (w_step) begin
            r_digit <= (r_digit == 4'd0) ? MAX : r_digit - 4'd1;
        end
    end

endmodule

// File: rtl/maze_timer.sv
// HangMaze countdown timer: M:SS BCD digits, per-second decrement, wrong-guess penalty, expiry flag.
module maze_timer
    import maze_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int INIT_MIN      = 2,
    parameter int INIT_TENS     = 0,
    parameter int INIT_ONES     = 0,
    parameter int PENALTY_SEC   = 10
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       pause,
    input  logic       restart,
    input  logic       penalty,
    output logic [3:0] min_digit,
    output logic [3:0] tens_digit,
    output logic [3:0] ones_digit,
    output logic       running,
    output logic       sec_pulse,
    output logic       expired
);

    localparam int          PW       = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] TERM   = PW'(TICKS_PER_SEC - 1);
    localparam logic [11:0] INIT_BCD = {4'(INIT_MIN), 4'(INIT_TENS), 4'(INIT_ONES)};
    localparam logic [9:0]  PENALTY  = 10'(PENALTY_SEC);

    timer_state_t  r_state, w_next_state;
    logic [PW-1:0] r_presc, w_next_presc;
    logic          r_running, r_sec_pulse, r_expired;
    logic          w_tick, w_at_one, w_sec_pulse;
    logic          w_dec, w_load;
    logic [11:0]   w_load_bcd;
    logic [9:0]    w_total, w_pen_total;
    logic          w_ones_borrow, w_tens_borrow, w_min_borrow;

    assign w_tick      = (r_state == RUN) && (r_presc == TERM);
    assign w_at_one    = (min_digit == 4'd0) && (tens_digit == 4'd0) && (ones_digit == 4'd1);
    assign w_total     = bcd_to_seconds(min_digit, tens_digit, ones_digit);
    assign w_pen_total = (w_total > PENALTY) ? w_total - PENALTY : 10'd0;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_presc     <= '0;
            r_running   <= 1'b0;
            r_sec_pulse <= 1'b0;
            r_expired   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_presc     <= w_next_presc;
            r_running   <= (w_next_state == RUN);
            r_sec_pulse <= w_sec_pulse;
            r_expired   <= (w_next_state == EXPIRED);
        end
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_presc = r_presc;
        w_dec        = 1'b0;
        w_load       = 1'b0;
        w_load_bcd   = INIT_BCD;
        w_sec_pulse  = 1'b0;

        if (restart) begin
            w_load       = 1'b1;
            w_next_presc = '0;
            w_next_state = IDLE;
        end else begin
            // The prescaler keeps its cadence in RUN even when a penalty swallows the tick.
            if (r_state == RUN) begin
                w_next_presc = w_tick ? '0 : r_presc + 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        w_next_presc = '0;
                        w_next_state = (INIT_BCD == 12'h000) ? EXPIRED : RUN;
                    end
                end
                RUN: begin
                    if (penalty) begin
                        w_load     = 1'b1;
                        w_load_bcd = seconds_to_bcd(w_pen_total);
                        if (w_pen_total == 10'd0) w_next_state = EXPIRED;
                    end else if (w_tick) begin
                        w_dec       = 1'b1;
                        w_sec_pulse = 1'b1;
                        if (w_at_one) w_next_state = EXPIRED;
                    end else if (pause) begin
                        w_next_presc = r_presc;
                        w_next_state = PAUSE;
                    end
                end
                PAUSE: begin
                    if (penalty) begin
                        w_load     = 1'b1;
                        w_load_bcd = seconds_to_bcd(w_pen_total);
                        if (w_pen_total == 10'd0) w_next_state = EXPIRED;
                    end else if (start) begin
                        w_next_state = RUN;
                    end
                end
                EXPIRED: ;
                default: w_next_state = IDLE;
            endcase
        end
    end

    bcd_digit_down #(.MAX(BCD_MAX_ONES), .INIT(INIT_BCD[3:0])) u_ones (
        .clk(Clk), .rst_n(reset_n), .dec(w_dec), .borrow_in(1'b1),
        .load(w_load), .load_val(w_load_bcd[3:0]),
        .digit(ones_digit), .borrow_out(w_ones_borrow)
    );

    bcd_digit_down #(.MAX(BCD_MAX_TENS), .INIT(INIT_BCD[7:4])) u_tens (
        .clk(Clk), .rst_n(reset_n), .dec(w_dec), .borrow_in(w_ones_borrow),
        .load(w_load), .load_val(w_load_bcd[7:4]),
        .digit(tens_digit), .borrow_out(w_tens_borrow)
    );

    bcd_digit_down #(.MAX(BCD_MAX_MIN), .INIT(INIT_BCD[11:8])) u_min (
        .clk(Clk), .rst_n(reset_n), .dec(w_dec), .borrow_in(w_tens_borrow),
        .load(w_load), .load_val(w_load_bcd[11:8]),
        .digit(min_digit), .borrow_out(w_min_borrow)
    );

    assign running   = r_running;
    assign sec_pulse = r_sec_pulse;
    assign expired   = r_expired;

endmodule

// File: tb/tb_maze_timer.sv
// Self-checking bench for maze_timer: vector table plus hand sequences, scoreboard-queued expectations.
module tb_maze_timer;

    typedef struct {
        string      name;
        logic       st;
        logic       pa;
        logic       rs;
        logic       pe;
        int         wait_cyc;
        logic [11:0] bcd;
        logic       exp_run;
        logic       exp_exp;
        logic       exp_sec;
    } vec_t;

    typedef struct {
        string       name;
        logic [11:0] bcd;
        logic        exp_run;
        logic        exp_exp;
        logic        exp_sec;
    } exp_t;

    logic       Clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0, pause = 1'b0, restart = 1'b0, penalty = 1'b0;
    logic [3:0] min_digit, tens_digit, ones_digit;
    logic       running, sec_pulse, expired;

    logic       z_start = 1'b0;
    logic [3:0] z_min, z_tens, z_ones;
    logic       z_running, z_sec_pulse, z_expired;

    int   checks = 0;
    int   failures = 0;
    int   pulse_cnt = 0;
    int   pulse_base;
    exp_t sb_q[$];
    vec_t vecs[21];

    always #5 Clk = ~Clk;

    maze_timer #(
        .TICKS_PER_SEC(4), .INIT_MIN(2), .INIT_TENS(0), .INIT_ONES(0), .PENALTY_SEC(10)
    ) u_dut (
        .Clk(Clk), .reset_n(reset_n), .start(start), .pause(pause), .restart(restart),
        .penalty(penalty), .min_digit(min_digit), .tens_digit(tens_digit),
        .ones_digit(ones_digit), .running(running), .sec_pulse(sec_pulse), .expired(expired)
    );

    maze_timer #(
        .TICKS_PER_SEC(4), .INIT_MIN(0), .INIT_TENS(0), .INIT_ONES(0), .PENALTY_SEC(10)
    ) u_zero (
        .Clk(Clk), .reset_n(reset_n), .start(z_start), .pause(1'b0), .restart(1'b0),
        .penalty(1'b0), .min_digit(z_min), .tens_digit(z_tens), .ones_digit(z_ones),
        .running(z_running), .sec_pulse(z_sec_pulse), .expired(z_expired)
    );

    always @(negedge Clk) if (sec_pulse === 1'b1) pulse_cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] sec2bcd(int s);
        logic [3:0] m, t, o;
        m = 4'(s / 60);
        t = 4'((s % 60) / 10);
        o = 4'(s % 10);
        return {m, t, o};
    endfunction

    task automatic check(string name, int actual, int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic expect_now(string name, logic [11:0] bcd, logic r, logic e, logic s);
        exp_t x;
        x.name = name; x.bcd = bcd; x.exp_run = r; x.exp_exp = e; x.exp_sec = s;
        sb_q.push_back(x);
    endtask

    task automatic compare_out();
        exp_t x;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: got=0 expected=1");
            return;
        end
        x = sb_q.pop_front();
        check({x.name, "_digits"}, int'({min_digit, tens_digit, ones_digit}), int'(x.bcd));
        check({x.name, "_running"}, int'(running), int'(x.exp_run));
        check({x.name, "_expired"}, int'(expired), int'(x.exp_exp));
        check({x.name, "_sec_pulse"}, int'(sec_pulse), int'(x.exp_sec));
    endtask

    // Pulse the inputs for one edge, then idle until wait_cyc edges have passed and compare.
    task automatic apply_vec(vec_t v);
        start = v.st; pause = v.pa; restart = v.rs; penalty = v.pe;
        expect_now(v.name, v.bcd, v.exp_run, v.exp_exp, v.exp_sec);
        @(negedge Clk);
        start = 1'b0; pause = 1'b0; restart = 1'b0; penalty = 1'b0;
        repeat (v.wait_cyc - 1) @(negedge Clk);
        compare_out();
    endtask

    task automatic drive(string name, logic st, logic pa, logic rs, logic pe, int w,
                         logic [11:0] bcd, logic r, logic e, logic s);
        vec_t v;
        v = '{name, st, pa, rs, pe, w, bcd, r, e, s};
        apply_vec(v);
    endtask

    initial begin
        //          name           st pa rs pe wait  digits   run exp sec
        vecs[0]  = '{"idle_hold",    0, 0, 0, 0, 3,  12'h200, 0, 0, 0};
        vecs[1]  = '{"idle_pause",   0, 1, 0, 0, 1,  12'h200, 0, 0, 0};
        vecs[2]  = '{"idle_penalty", 0, 0, 0, 1, 1,  12'h200, 0, 0, 0};
        vecs[3]  = '{"start",        1, 0, 0, 0, 1,  12'h200, 1, 0, 0};
        vecs[4]  = '{"pre_tick",     0, 0, 0, 0, 3,  12'h200, 1, 0, 0};
        vecs[5]  = '{"first_tick",   0, 0, 0, 0, 1,  12'h159, 1, 0, 1};
        vecs[6]  = '{"pulse_drop",   0, 0, 0, 0, 1,  12'h159, 1, 0, 0};
        vecs[7]  = '{"presc_two",    0, 0, 0, 0, 1,  12'h159, 1, 0, 0};
        vecs[8]  = '{"pause",        0, 1, 0, 0, 1,  12'h159, 0, 0, 0};
        vecs[9]  = '{"pause_hold",   0, 0, 0, 0, 20, 12'h159, 0, 0, 0};
        vecs[10] = '{"resume",       1, 0, 0, 0, 1,  12'h159, 1, 0, 0};
        vecs[11] = '{"resume_wait",  0, 0, 0, 0, 1,  12'h159, 1, 0, 0};
        vecs[12] = '{"resume_tick",  0, 0, 0, 0, 1,  12'h158, 1, 0, 1};
        vecs[13] = '{"run_penalty",  0, 0, 0, 1, 1,  12'h148, 1, 0, 0};
        vecs[14] = '{"pause2",       0, 1, 0, 0, 1,  12'h148, 0, 0, 0};
        vecs[15] = '{"pause_penalty",0, 0, 0, 1, 1,  12'h138, 0, 0, 0};
        vecs[16] = '{"pause_pause",  0, 1, 0, 0, 2,  12'h138, 0, 0, 0};
        vecs[17] = '{"resume2",      1, 0, 0, 0, 1,  12'h138, 1, 0, 0};
        vecs[18] = '{"resume2_wait", 0, 0, 0, 0, 2,  12'h138, 1, 0, 0};
        vecs[19] = '{"restart_pen",  0, 0, 1, 1, 1,  12'h200, 0, 0, 0};
        vecs[20] = '{"restart_idle", 0, 0, 0, 0, 6,  12'h200, 0, 0, 0};

        // Reset state
        repeat (2) @(negedge Clk);
        expect_now("reset", 12'h200, 0, 0, 0);
        compare_out();
        reset_n = 1'b1;
        @(negedge Clk);

        // Zero initial time: start goes straight to EXPIRED
        z_start = 1'b1;
        @(negedge Clk);
        z_start = 1'b0;
        check("zero_start_expired", int'(z_expired), 1);
        check("zero_start_running", int'(z_running), 0);
        check("zero_start_digits", int'({z_min, z_tens, z_ones}), 0);

        foreach (vecs[i]) apply_vec(vecs[i]);

        // Back-to-back penalties, two of them coincident with a prescaler wrap
        drive("b_start", 1, 0, 0, 0, 1, 12'h200, 1, 0, 0);
        penalty = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            expect_now($sformatf("burst_%0d", k), sec2bcd(120 - 10 * k), 1, 0, 0);
            @(negedge Clk);
            if (k == 11) penalty = 1'b0;
            compare_out();
        end
        expect_now("b_tick_9", 12'h009, 1, 0, 1);
        @(negedge Clk);
        compare_out();
        for (int s = 8; s >= 7; s--) begin
            expect_now($sformatf("b_tick_%0d", s), sec2bcd(s), 1, 0, 1);
            repeat (4) @(negedge Clk);
            compare_out();
        end
        drive("b_penalty_zero", 0, 0, 0, 1, 1, 12'h000, 0, 1, 0);
        drive("exp_penalty", 0, 0, 0, 1, 2, 12'h000, 0, 1, 0);
        drive("exp_start", 1, 0, 0, 0, 4, 12'h000, 0, 1, 0);
        drive("exp_restart", 0, 0, 1, 0, 1, 12'h200, 0, 0, 0);

        // Full countdown from 2:00 through the 1:00 -> 0:59 borrow to expiry
        drive("d_start", 1, 0, 0, 0, 1, 12'h200, 1, 0, 0);
        #1 pulse_base = pulse_cnt;
        for (int s = 1; s <= 120; s++) begin
            expect_now($sformatf("d_sec_%0d", s), sec2bcd(120 - s), s < 120, s == 120, 1);
            repeat (4) @(negedge Clk);
            compare_out();
        end
        #1 check("d_pulse_count", pulse_cnt - pulse_base, 120);
        drive("d_expired_hold", 0, 0, 0, 0, 8, 12'h000, 0, 1, 0);

        // Asynchronous reset in the middle of a count
        drive("e_restart", 0, 0, 1, 0, 1, 12'h200, 0, 0, 0);
        drive("e_start", 1, 0, 0, 0, 1, 12'h200, 1, 0, 0);
        expect_now("e_at_137", 12'h137, 1, 0, 1);
        repeat (92) @(negedge Clk);
        compare_out();
        repeat (2) @(negedge Clk);
        #2 reset_n = 1'b0;
        expect_now("e_async_reset", 12'h200, 0, 0, 0);
        #1 compare_out();
        @(negedge Clk);
        reset_n = 1'b1;
        drive("e_idle_100", 0, 0, 0, 0, 100, 12'h200, 0, 0, 0);
        drive("e_restart_run", 1, 0, 0, 0, 1, 12'h200, 1, 0, 0);
        drive("e_no_residual", 0, 0, 0, 0, 3, 12'h200, 1, 0, 0);
        drive("e_fresh_tick", 0, 0, 0, 0, 1, 12'h159, 1, 0, 1);

        check("scoreboard_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
